// File: rtl/deser_lanes_if.sv
// deser_lanes_if: beat-side and word-side handshake bundle for deser_lanes.
// master = the block driving beats and consuming words, slave = the deserializer.
interface deser_lanes_if #(
  parameter int WORD_WD = 8,
  parameter int LANES   = 1
);
  logic               valid_in;
  logic [LANES-1:0]   data_in;
  logic               in_ready;
  logic               msb_first;
  logic               flush;
  logic [WORD_WD-1:0] data_out;
  logic               valid_out;
  logic               ready_out;
  logic               err_gap;

  modport master (
    output valid_in, data_in, msb_first, flush, ready_out,
    input  in_ready, data_out, valid_out, err_gap
  );

  modport slave (
    input  valid_in, data_in, msb_first, flush, ready_out,
    output in_ready, data_out, valid_out, err_gap
  );
endinterface

// File: rtl/deser_lanes.sv
// deser_lanes: LANES-bit beats assembled into WORD_WD-bit words, either bit
// order, ready/valid output with one output register plus one held word.
// Optional feature macro: DESER_GAP_TIMEOUT_EN (drop a partial word after
// GAP_CYCLES consecutive idle cycles and pulse err_gap).

// One lane's contribution to the word: its bit placed in the selected beat slot.
module deser_lanes_lane #(
  parameter int WORD_WD  = 8,
  parameter int LANES    = 1,
  parameter int LANE_IDX = 0,
  parameter int CW       = 3
) (
  input  logic [CW-1:0]      i_slot,
  input  logic               i_bit,
  output logic [WORD_WD-1:0] o_word
);
  localparam int BEATS = WORD_WD / LANES;

  // Steer the lane bit to slot*LANES+LANE_IDX, everything else zero.
  always_comb begin
    o_word = '0;
    for (int b = 0; b < BEATS; b++)
      if (i_slot == CW'(b)) o_word[b*LANES+LANE_IDX] = i_bit;
  end
endmodule

module deser_lanes #(
  parameter int WORD_WD    = 8,
  parameter int LANES      = 1,
  parameter int GAP_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  deser_lanes_if.slave bus
);
  localparam int BEATS = WORD_WD / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_cnt;
  logic                           r_msb;
  logic [WORD_WD-1:0]             r_shift;
  logic [WORD_WD-1:0]             r_dout;
  logic                           r_vout;

  logic [CW-1:0]                  w_slot;
  logic                           w_msb;
  logic                           w_first;
  logic                           w_last;
  logic                           w_in_ready;
  logic                           w_beat;
  logic                           w_out_free;
  logic                           w_load;
  logic                           w_timeout;
  logic [WORD_WD-1:0]             w_base;
  logic [WORD_WD-1:0]             w_word;
  logic [WORD_WD-1:0]             w_load_data;
  logic [LANES-1:0][WORD_WD-1:0]  w_lane_word;

  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == CW'(BEATS-1));
  assign w_in_ready = (r_state != STALL);
  // A flush in the same cycle swallows the beat.
  assign w_beat     = bus.valid_in && w_in_ready && !bus.flush;
  assign w_out_free = !r_vout || bus.ready_out;
  // Order comes live from the port on beat 0, latched for the rest of the word.
  assign w_msb      = w_first ? bus.msb_first : r_msb;
  // MSB-first fills slots from the top down.
  assign w_slot     = w_msb ? (CW'(BEATS-1) - r_cnt) : r_cnt;
  // Starting a word from zero keeps unwritten bits clear.
  assign w_base     = w_first ? '0 : r_shift;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    deser_lanes_lane #(
      .WORD_WD (WORD_WD),
      .LANES   (LANES),
      .LANE_IDX(g),
      .CW      (CW)
    ) u_lane (
      .i_slot(w_slot),
      .i_bit (bus.data_in[g]),
      .o_word(w_lane_word[g])
    );
  end

  // Merge all lane contributions onto the partial word.
  always_comb begin
    w_word = w_base;
    for (int l = 0; l < LANES; l++) w_word = w_word | w_lane_word[l];
  end

  // Output register loads a freshly completed word or the held STALL word.
  assign w_load      = (w_beat && w_last && w_out_free) ||
                       ((r_state == STALL) && bus.ready_out);
  assign w_load_data = (r_state == STALL) ? r_shift : w_word;

  // Assembly FSM: beat counter, bit-order latch, shift register, state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE, SHIFT: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_beat) begin
            if (w_first) r_msb <= bus.msb_first;
            if (w_last) begin
              r_cnt <= '0;
              if (w_out_free) begin
                r_state <= IDLE;
              end else begin
                r_state <= STALL;
                r_shift <= w_word;
              end
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_shift <= w_word;
              r_state <= SHIFT;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        STALL: begin
          // Held word moves to the output register on the accept edge.
          if (bus.ready_out) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: holds data after acceptance until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_vout <= 1'b0;
    end else if (w_load) begin
      r_dout <= w_load_data;
      r_vout <= 1'b1;
    end else if (bus.ready_out) begin
      r_vout <= 1'b0;
    end
  end

`ifdef DESER_GAP_TIMEOUT_EN
  localparam int IW = $clog2(GAP_CYCLES + 1);

  logic [IW-1:0] r_idle;
  logic          r_err;

  // Fires on the cycle that would be the GAP_CYCLES-th consecutive idle one.
  assign w_timeout = (r_state == SHIFT) && !bus.valid_in && !bus.flush &&
                     (r_idle == IW'(GAP_CYCLES-1));

  // Idle counter runs only inside a word; err_gap pulses on the drop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if ((r_state != SHIFT) || bus.valid_in || bus.flush || w_timeout)
        r_idle <= '0;
      else
        r_idle <= r_idle + IW'(1);
    end
  end

  assign bus.err_gap = r_err;
`else
  // GAP_CYCLES has no effect without the timeout; gaps of any length are fine.
  assign w_timeout   = 1'b0 && (GAP_CYCLES > 0);
  assign bus.err_gap = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.data_out  = r_dout;
  assign bus.valid_out = r_vout;
endmodule

// File: tb/tb_deser_lanes.sv
// tb_deser_lanes: scoreboard bench for deser_lanes, one LANES=1 and one
// LANES=4 instance (both WORD_WD=8, GAP_CYCLES=4).
module tb_deser_lanes;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deser_lanes_if #(.WORD_WD(8), .LANES(1)) ifa ();
  deser_lanes_if #(.WORD_WD(8), .LANES(4)) ifb ();

  deser_lanes #(.WORD_WD(8), .LANES(1), .GAP_CYCLES(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  deser_lanes #(.WORD_WD(8), .LANES(4), .GAP_CYCLES(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

`ifdef DESER_GAP_TIMEOUT_EN
  localparam int GAP_IDLE = 3;
`else
  localparam int GAP_IDLE = 5;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int acc_b[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every accepted word against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.valid_out && ifa.ready_out) begin
        if (qa.size() > 0) chk("a_word", ifa.data_out, qa.pop_front());
        else chk("a_unexpected", qa.size(), 1);
      end
      if (ifb.valid_out && ifb.ready_out) begin
        acc_b.push_back(cyc);
        if (qb.size() > 0) chk("b_word", ifb.data_out, qb.pop_front());
        else chk("b_unexpected", qb.size(), 1);
      end
      if (ifa.err_gap) err_seen++;
      if (ifb.err_gap) err_seen++;
    end
  end

  task automatic a_beat(logic b, logic msb);
    int n = 0;
    while (!ifa.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) chk("a_in_ready_timeout", ifa.in_ready, 1);
    ifa.valid_in = 1'b1; ifa.data_in = b; ifa.msb_first = msb;
    @(posedge clk); #1;
    ifa.valid_in = 1'b0;
  endtask

  task automatic b_beat(logic [3:0] d, logic msb);
    int n = 0;
    while (!ifb.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) chk("b_in_ready_timeout", ifb.in_ready, 1);
    ifb.valid_in = 1'b1; ifb.data_in = d; ifb.msb_first = msb;
    @(posedge clk); #1;
    ifb.valid_in = 1'b0;
  endtask

  // Send beats s[from] .. s[to-1] on the single-lane instance.
  task automatic a_stream(logic [7:0] s, int from, int to, logic msb);
    for (int k = from; k < to; k++) a_beat(s[k], msb);
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [7:0] s1;
  logic [7:0] s2;

  initial begin
    s1 = 8'b0100_1101;  // beat order 1,0,1,1,0,0,1,0
    s2 = 8'h96;
    ifa.valid_in = 0; ifa.data_in = '0; ifa.msb_first = 0; ifa.flush = 0; ifa.ready_out = 1;
    ifb.valid_in = 0; ifb.data_in = '0; ifb.msb_first = 0; ifb.flush = 0; ifb.ready_out = 1;

    #12;
    chk("rst_a_vout", ifa.valid_out, 0);
    chk("rst_a_dout", ifa.data_out, 0);
    chk("rst_a_inrdy", ifa.in_ready, 1);
    chk("rst_a_err", ifa.err_gap, 0);
    chk("rst_b_vout", ifb.valid_out, 0);
    chk("rst_b_inrdy", ifb.in_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single lane, LSB-first then MSB-first.
    qa.push_back(8'h4D);
    a_stream(s1, 0, 8, 0);
    chk("a_vout_hi", ifa.valid_out, 1);
    idle(1);
    chk("a_vout_one_cycle", ifa.valid_out, 0);
    qa.push_back(8'hB2);
    a_stream(s1, 0, 8, 1);
    idle(2);

    // Four lanes, both orders.
    qb.push_back(8'hA5); b_beat(4'hA, 1); b_beat(4'h5, 1);
    qb.push_back(8'h5A); b_beat(4'hA, 0); b_beat(4'h5, 0);
    idle(2);

    // Four back-to-back words: accepts spaced two cycles apart.
    acc_b.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = 8'h12 + 8'(i * 8'h22);
      qb.push_back(w);
      b_beat(w[7:4], 1); b_beat(w[3:0], 1);
    end
    idle(2);
    chk("b_burst_count", acc_b.size(), 4);
    if (acc_b.size() == 4)
      for (int i = 1; i < 4; i++) chk("b_burst_spacing", acc_b[i] - acc_b[i-1], 2);

    // Backpressure: two words buffered, then drained.
    ifb.ready_out = 0;
    qb.push_back(8'h11); qb.push_back(8'h22);
    b_beat(4'h1, 1); b_beat(4'h1, 1); b_beat(4'h2, 1); b_beat(4'h2, 1);
    chk("bp_in_ready_low", ifb.in_ready, 0);
    chk("bp_vout", ifb.valid_out, 1);
    chk("bp_first_held", ifb.data_out, 8'h11);
    ifb.ready_out = 1;
    @(posedge clk); #1;
    chk("bp_second_vout", ifb.valid_out, 1);
    chk("bp_second_data", ifb.data_out, 8'h22);
    chk("bp_in_ready_back", ifb.in_ready, 1);
    idle(2);

    // Mid-word gap tolerated.
    qa.push_back(s2);
    a_stream(s2, 0, 3, 0);
    idle(GAP_IDLE);
    a_stream(s2, 3, 8, 0);
    idle(2);

    // Flush drops the partial word and the same-cycle beat.
    a_stream(8'hFF, 0, 3, 0);
    ifa.flush = 1; ifa.valid_in = 1; ifa.data_in = 1'b1;
    @(posedge clk); #1;
    ifa.flush = 0; ifa.valid_in = 0;
    qa.push_back(8'hC3);
    a_stream(8'hC3, 0, 8, 0);
    idle(2);

`ifdef DESER_GAP_TIMEOUT_EN
    // Timeout drop, then clean words.
    a_stream(8'hFF, 0, 3, 0);
    idle(4);
    err_exp++;
    idle(1);
    chk("gap_err_pulse", err_seen, err_exp);
    qa.push_back(8'h4D);
    a_stream(s1, 0, 8, 0);
    idle(2);
    qa.push_back(s2);
    a_stream(s2, 0, 3, 0);
    idle(3);
    a_stream(s2, 3, 8, 0);
    idle(2);
    chk("gap_no_err", err_seen, err_exp);
`endif

    // Asynchronous reset mid-word with a word pending on the output.
    ifa.ready_out = 0;
    a_stream(s1, 0, 8, 0);
    a_stream(s1, 0, 3, 0);
    chk("rst_pre_vout", ifa.valid_out, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_vout", ifa.valid_out, 0);
    chk("rst_async_dout", ifa.data_out, 0);
    chk("rst_async_inrdy", ifa.in_ready, 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ifa.ready_out = 1;
    qa.push_back(8'h5A);
    a_stream(8'h5A, 0, 8, 0);
    idle(3);

    chk("a_sb_drained", qa.size(), 0);
    chk("b_sb_drained", qb.size(), 0);
    chk("err_gap_count", err_seen, err_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
